// File: rtl/prim_ram_pkg.sv
// Shared definitions for the parity-protected single-port RAM.
//   ram_state_e : sequencer states (INIT = zero-fill running, READY = user access)
//   byte_parity : even-parity bit of one data byte
package prim_ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_state_e;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/prim_generic_ram_1p.sv
// Generic single-port synchronous RAM, read latency 1.
//   clk_i   : clock
//   req_i   : access enable
//   write_i : 1 = write, 0 = read
//   addr_i  : word address
//   wdata_i : write data
//   wmask_i : write mask, one enable per DataBitsPerMask-bit group (group LSB used)
//   rdata_o : read data, updated only by reads
// Array and output register are intentionally not reset.
module prim_generic_ram_1p #(
  parameter int Width           = 32,
  parameter int Depth           = 128,
  parameter int DataBitsPerMask = 1,
  parameter int Aw              = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             req_i,
  input  logic             write_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned NumGroups = Width / DataBitsPerMask;

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (write_i) begin
        for (int unsigned g = 0; g < NumGroups; g++) begin
          if (wmask_i[g*DataBitsPerMask]) begin
            mem[addr_i][g*DataBitsPerMask +: DataBitsPerMask] <=
              wdata_i[g*DataBitsPerMask +: DataBitsPerMask];
          end
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/prim_ram_1p_par.sv
// Single-port RAM with per-byte even parity, optional output register stage,
// hardware zero-fill sequencer and request/grant handshake.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i/gnt_o   : request / combinational grant (READY and no init request)
//   write_i       : 1 = write, 0 = read
//   addr_i        : word address
//   wdata_i       : write data
//   wmask_i       : bit write mask (constant per byte when parity is enabled)
//   wpar_inv_i    : invert stored parity of this write (fault injection)
//   init_req_i    : request a new zero-fill (sampled in READY)
//   init_done_o   : high in READY
//   rvalid_o      : read data valid (latency 1, or 2 with output pipe)
//   rdata_o       : read data, holds when rvalid_o=0
//   rerror_o      : per-byte parity error, qualified by rvalid_o
module prim_ram_1p_par
  import prim_ram_pkg::*;
#(
  parameter int Width            = 32,
  parameter int Depth            = 128,
  parameter int DataBitsPerMask  = 8,
  parameter int EnableParity     = 1,
  parameter int EnableOutputPipe = 0,
  parameter int EnableInit       = 1,
  parameter int Aw               = $clog2(Depth),
  parameter int NumPar           = (EnableParity != 0) ? Width / 8 : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              write_i,
  input  logic [Aw-1:0]     addr_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic [Width-1:0]  wmask_i,
  input  logic              wpar_inv_i,
  input  logic              init_req_i,
  output logic              init_done_o,
  output logic              rvalid_o,
  output logic [Width-1:0]  rdata_o,
  output logic [NumPar-1:0] rerror_o
);

  localparam int TotW = Width + NumPar;

  // Parameter legality
  if (EnableParity != 0 && (Width % 8) != 0) begin : gen_chk_width
    $error("prim_ram_1p_par: Width must be a multiple of 8 with parity");
  end
  if (EnableParity != 0 && DataBitsPerMask != 8) begin : gen_chk_mask
    $error("prim_ram_1p_par: DataBitsPerMask must be 8 with parity");
  end
  if (Depth < 2) begin : gen_chk_depth
    $error("prim_ram_1p_par: Depth must be at least 2");
  end

  // Init sequencer
  ram_state_e      state;
  logic [Aw-1:0]   cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= (EnableInit != 0) ? INIT : READY;
      cnt   <= '0;
    end else begin
      case (state)
        INIT: begin
          if (cnt == Aw'(Depth - 1)) begin
            state <= READY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          if (init_req_i && (EnableInit != 0)) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
        default: state <= READY;
      endcase
    end
  end

  assign init_done_o = (state == READY);
  assign gnt_o       = req_i & (state == READY) & ~init_req_i;

  // Parity generate / check
  logic [NumPar-1:0] wpar;
  logic [NumPar-1:0] pmask;
  logic [NumPar-1:0] rerr_raw;
  logic [TotW-1:0]   ram_rdata;

  if (EnableParity != 0) begin : gen_par
    for (genvar i = 0; i < NumPar; i++) begin : gen_byte
      assign wpar[i]     = byte_parity(wdata_i[8*i +: 8]) ^ wpar_inv_i;
      assign pmask[i]    = wmask_i[8*i];
      assign rerr_raw[i] = byte_parity(ram_rdata[8*i +: 8]) ^ ram_rdata[Width+i];
    end
  end else begin : gen_nopar
    logic unused_par;
    assign unused_par = ^{ram_rdata[Width +: NumPar], wpar_inv_i};
    assign wpar       = '0;
    assign pmask      = '0;
    assign rerr_raw   = '0;
  end

  // Storage port mux: init counter owns the array while in INIT
  logic            ram_req;
  logic            ram_write;
  logic [Aw-1:0]   ram_addr;
  logic [TotW-1:0] ram_wdata;
  logic [TotW-1:0] ram_wmask;

  always_comb begin
    ram_req   = gnt_o;
    ram_write = write_i;
    ram_addr  = addr_i;
    ram_wdata = {wpar, wdata_i};
    ram_wmask = {pmask, wmask_i};
    if (state == INIT) begin
      ram_req   = 1'b1;
      ram_write = 1'b1;
      ram_addr  = cnt;
      ram_wdata = '0;
      ram_wmask = '1;
    end
  end

  prim_generic_ram_1p #(
    .Width           (TotW),
    .Depth           (Depth),
    .DataBitsPerMask (1),
    .Aw              (Aw)
  ) u_mem (
    .clk_i   (clk_i),
    .req_i   (ram_req),
    .write_i (ram_write),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .wmask_i (ram_wmask),
    .rdata_o (ram_rdata)
  );

  // Read tracking
  logic rd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= 1'b0;
    end else begin
      rd_q <= gnt_o & ~write_i;
    end
  end

  if (EnableOutputPipe != 0) begin : gen_pipe
    logic              rvalid_q;
    logic [Width-1:0]  rdata_q;
    logic [NumPar-1:0] rerr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
        rerr_q   <= '0;
      end else begin
        rvalid_q <= rd_q;
        if (rd_q) begin
          rdata_q <= ram_rdata[Width-1:0];
          rerr_q  <= rerr_raw;
        end
      end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign rerror_o = rerr_q;
  end else begin : gen_nopipe
    // The RAM output register is not reset, so a shadow copy supplies the
    // reset value and the hold value between reads.
    logic [Width-1:0]  rdata_h;
    logic [NumPar-1:0] rerr_h;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rdata_h <= '0;
        rerr_h  <= '0;
      end else if (rd_q) begin
        rdata_h <= ram_rdata[Width-1:0];
        rerr_h  <= rerr_raw;
      end
    end

    assign rvalid_o = rd_q;
    assign rdata_o  = rd_q ? ram_rdata[Width-1:0] : rdata_h;
    assign rerror_o = rd_q ? rerr_raw : rerr_h;
  end

endmodule

// File: tb/tb_prim_ram_1p_par.sv
module tb_prim_ram_1p_par;

  localparam int W  = 32;
  localparam int D  = 128;
  localparam int AW = 7;
  localparam int NP = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          req   = 1'b0;
  logic          wr    = 1'b0;
  logic          winv  = 1'b0;
  logic          ireq  = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  wmask = '0;

  logic          gnt0, done0, rv0;
  logic [W-1:0]  rd0;
  logic [NP-1:0] re0;
  logic          gnt1, done1, rv1;
  logic [W-1:0]  rd1;
  logic [NP-1:0] re1;

  int total = 0;
  int bad   = 0;

  // Reference: word contents plus a per-byte "stored with inverted parity" flag
  logic [W-1:0]  m_data [D];
  logic [NP-1:0] m_bad  [D];

  always #5 clk = ~clk;

  prim_ram_1p_par #(
    .Width(W), .Depth(D), .DataBitsPerMask(8), .EnableParity(1),
    .EnableOutputPipe(0), .EnableInit(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt0), .write_i(wr),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .wpar_inv_i(winv),
    .init_req_i(ireq), .init_done_o(done0), .rvalid_o(rv0), .rdata_o(rd0),
    .rerror_o(re0)
  );

  prim_ram_1p_par #(
    .Width(W), .Depth(D), .DataBitsPerMask(8), .EnableParity(1),
    .EnableOutputPipe(1), .EnableInit(1)
  ) dut_p (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt1), .write_i(wr),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .wpar_inv_i(winv),
    .init_req_i(ireq), .init_done_o(done1), .rvalid_o(rv1), .rdata_o(rd1),
    .rerror_o(re1)
  );

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      m_data[i] = '0;
      m_bad[i]  = '0;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d,
                          input logic [NP-1:0] bm, input logic inv);
    logic [W-1:0] m;
    m = '0;
    for (int b = 0; b < NP; b++) if (bm[b]) m[8*b +: 8] = 8'hFF;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = a; wdata = d; wmask = m; winv = inv;
    #1;
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b1) begin
      bad++;
      $display("FAIL write_gnt addr=%0d got=%b/%b want=1", a, gnt0, gnt1);
    end
    @(posedge clk); #1;
    req = 1'b0; wr = 1'b0; winv = 1'b0;
    total++;
    if (rv0 !== 1'b0 || rv1 !== 1'b0) begin
      bad++;
      $display("FAIL write_no_rvalid addr=%0d got=%b/%b want=0", a, rv0, rv1);
    end
    for (int b = 0; b < NP; b++) begin
      if (bm[b]) begin
        m_data[a][8*b +: 8] = d[8*b +: 8];
        m_bad[a][b]         = inv;
      end
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    logic [W-1:0]  ed;
    logic [NP-1:0] ee;
    ed = m_data[a];
    ee = m_bad[a];
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = a;
    #1;
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b1) begin
      bad++;
      $display("FAIL read_gnt addr=%0d got=%b/%b want=1", a, gnt0, gnt1);
    end
    @(posedge clk); #1;
    req = 1'b0;
    total++;
    if (rv0 !== 1'b1 || rd0 !== ed || re0 !== ee || rv1 !== 1'b0) begin
      bad++;
      $display("FAIL read_lat1 addr=%0d got rv=%b d=%h e=%b rvp=%b want rv=1 d=%h e=%b rvp=0",
               a, rv0, rd0, re0, rv1, ed, ee);
    end
    @(posedge clk); #1;
    total++;
    if (rv1 !== 1'b1 || rd1 !== ed || re1 !== ee || rv0 !== 1'b0 || rd0 !== ed || re0 !== ee) begin
      bad++;
      $display("FAIL read_lat2 addr=%0d got rvp=%b dp=%h ep=%b rv=%b d=%h e=%b want rvp=1 d=%h e=%b rv=0 hold",
               a, rv1, rd1, re1, rv0, rd0, re0, ed, ee);
    end
  endtask

  // Holds req high and counts edges until init_done; nothing may be granted meanwhile.
  task automatic wait_init(input string name, input int expect_cycles);
    int   n;
    logic gbad;
    n    = 0;
    gbad = 1'b0;
    req  = 1'b1;
    wr   = 1'b0;
    while (n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (done0 === 1'b1) break;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0) gbad = 1'b1;
    end
    req = 1'b0;
    total++;
    if (n != expect_cycles || done0 !== 1'b1 || done1 !== 1'b1) begin
      bad++;
      $display("FAIL %s_cycles got=%0d done=%b/%b want=%0d done=1", name, n, done0, done1, expect_cycles);
    end
    total++;
    if (gbad !== 1'b0) begin
      bad++;
      $display("FAIL %s_gnt_during_init got=1 want=0", name);
    end
    model_clear();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rv0 !== 1'b0 || rd0 !== '0 || re0 !== '0 || done0 !== 1'b0 ||
        rv1 !== 1'b0 || rd1 !== '0 || re1 !== '0 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got rv=%b/%b d=%h/%h e=%b/%b done=%b/%b want all 0",
               rv0, rv1, rd0, rd1, re0, re1, done0, done1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("reset_init", D);
    do_read(AW'(0));
    do_read(AW'(D - 1));
    do_read(AW'($urandom_range(1, D - 2)));
  endtask

  task automatic test_full_write();
    do_write(AW'(5), 32'hA5A5_1234, 4'hF, 1'b0);
    do_read(AW'(5));
  endtask

  task automatic test_masked_parity();
    do_write(AW'(9), 32'hFFFF_FFFF, 4'b0010, 1'b0);
    do_read(AW'(9));
    total++;
    if (m_data[9] !== 32'h0000_FF00) begin
      bad++;
      $display("FAIL masked_model got=%h want=0000ff00", m_data[9]);
    end
  endtask

  task automatic test_parity_inject();
    do_write(AW'(10), 32'h1234_5678, 4'b0100, 1'b1);
    do_read(AW'(10));
    total++;
    if (re0 !== 4'b0100 || rd0 !== 32'h0034_0000) begin
      bad++;
      $display("FAIL parity_inject got d=%h e=%b want d=00340000 e=0100", rd0, re0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, NP'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      else
        do_read(a);
    end
  endtask

  task automatic test_back_to_back();
    logic          s_rv0 [5];
    logic          s_rv1 [5];
    logic [W-1:0]  s_d0  [5];
    logic [W-1:0]  s_d1  [5];
    logic [W-1:0]  ed    [3];
    for (int i = 1; i <= 3; i++) do_write(AW'(i), $urandom, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) ed[i] = m_data[i+1];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req = 1'b1; wr = 1'b0; addr = AW'(i + 1);
      @(posedge clk); #1;
      s_rv0[i] = rv0; s_rv1[i] = rv1; s_d0[i] = rd0; s_d1[i] = rd1;
    end
    @(negedge clk);
    req = 1'b0;
    for (int i = 3; i < 5; i++) begin
      @(posedge clk); #1;
      s_rv0[i] = rv0; s_rv1[i] = rv1; s_d0[i] = rd0; s_d1[i] = rd1;
    end
    for (int i = 0; i < 5; i++) begin
      logic want0, want1;
      want0 = (i <= 2);
      want1 = (i >= 1 && i <= 3);
      total++;
      if (s_rv0[i] !== want0 || s_rv1[i] !== want1 ||
          (want0 && s_d0[i] !== ed[i]) || (want1 && s_d1[i] !== ed[i-1])) begin
        bad++;
        $display("FAIL b2b_cycle%0d got rv=%b rvp=%b d=%h dp=%h want rv=%b rvp=%b",
                 i + 1, s_rv0[i], s_rv1[i], s_d0[i], s_d1[i], want0, want1);
      end
    end
  endtask

  task automatic test_init_req();
    do_write(AW'(20), 32'hDEAD_BEEF, 4'hF, 1'b1);
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = AW'(20); ireq = 1'b1;
    #1;
    total++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      bad++;
      $display("FAIL init_req_gnt got=%b/%b want=0", gnt0, gnt1);
    end
    @(posedge clk); #1;
    ireq = 1'b0; req = 1'b0;
    total++;
    if (done0 !== 1'b0 || rv0 !== 1'b0) begin
      bad++;
      $display("FAIL init_req_enter got done=%b rv=%b want done=0 rv=0", done0, rv0);
    end
    wait_init("init_req", D);
    do_read(AW'(5));
    do_read(AW'(10));
    do_read(AW'(20));
  endtask

  task automatic test_mid_init_reset();
    do_write(AW'(7), 32'h0BAD_F00D, 4'hF, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (done0 !== 1'b0 || done1 !== 1'b0 || rv1 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_state got done=%b/%b rvp=%b want 0", done0, done1, rv1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("mid_reset_init", D);
    do_read(AW'(7));
  endtask

  initial begin
    model_clear();
    test_reset();
    test_full_write();
    test_masked_parity();
    test_parity_inject();
    test_random();
    test_back_to_back();
    test_init_req();
    test_mid_init_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
